// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: accumulates OFIFO psum rows into SRAM over kij passes.
// The final pass can optionally clamp negative lanes to zero.
module psum_acc_ctrl #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int num_inp = 64,
   parameter int kij_len = 9,
   parameter int addr_bw = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     relu,
   input  logic                     o_valid,
   output logic                     ofifo_rd,
   input  logic [col*psum_bw-1:0]   ofifo_dout,
   output logic                     mem_cen,
   output logic                     mem_wen,
   output logic [addr_bw-1:0]       mem_addr,
   output logic [col*psum_bw-1:0]   mem_din,
   input  logic [col*psum_bw-1:0]   mem_dout,
   output logic                     busy,
   output logic                     iter_done,
   output logic                     compute_done
);
   localparam int dw = col*psum_bw;
   localparam int kw = kij_len > 1 ? $clog2(kij_len) : 1;
   localparam logic [addr_bw-1:0] row_last = addr_bw'(num_inp-1);
   localparam logic [kw-1:0] kij_last = kw'(kij_len-1);

   typedef enum logic [2:0] {IDLE, POP, RD_MEM, ADD, WRITE, DONE} state_t;

   state_t             state_q, state_d;
   logic [addr_bw-1:0] row_cnt_q, row_cnt_d;
   logic [kw-1:0]      kij_cnt_q, kij_cnt_d;
   logic [dw-1:0]      fifo_reg_q, fifo_reg_d, sum_q, sum_d, wr_raw, wr_data;
   logic               relu_q, relu_d, iter_done_q, iter_done_d, clamp;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         kij_cnt_q   <= '0;
         fifo_reg_q  <= '0;
         sum_q       <= '0;
         relu_q      <= 1'b0;
         iter_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         kij_cnt_q   <= kij_cnt_d;
         fifo_reg_q  <= fifo_reg_d;
         sum_q       <= sum_d;
         relu_q      <= relu_d;
         iter_done_q <= iter_done_d;
      end

   // First pass writes the row directly; later passes write the accumulated sum
   always_comb begin
      wr_raw  = kij_cnt_q == '0 ? fifo_reg_q : sum_q;
      clamp   = relu_q && kij_cnt_q == kij_last;
      wr_data = wr_raw;
      for (int i = 0; i < col; i++)
         wr_data[i*psum_bw +: psum_bw] = (clamp && wr_raw[i*psum_bw+psum_bw-1]) ? '0 : wr_raw[i*psum_bw +: psum_bw];
   end

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      kij_cnt_d   = kij_cnt_q;
      fifo_reg_d  = fifo_reg_q;
      sum_d       = sum_q;
      relu_d      = relu_q;
      iter_done_d = 1'b0;
      ofifo_rd    = 1'b0;
      mem_cen     = 1'b1;
      mem_wen     = 1'b1;
      mem_addr    = '0;
      mem_din     = '0;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d   = POP;
            row_cnt_d = '0;
            kij_cnt_d = '0;
            relu_d    = relu;
         end
         POP: if (o_valid) begin
            ofifo_rd   = 1'b1;
            fifo_reg_d = ofifo_dout;
            state_d    = kij_cnt_q == '0 ? WRITE : RD_MEM;
         end
         RD_MEM: begin
            mem_cen  = 1'b0;
            mem_addr = row_cnt_q;
            state_d  = ADD;
         end
         ADD: begin
            for (int i = 0; i < col; i++)
               sum_d[i*psum_bw +: psum_bw] = mem_dout[i*psum_bw +: psum_bw] + fifo_reg_q[i*psum_bw +: psum_bw];
            state_d = WRITE;
         end
         WRITE: begin
            mem_cen  = 1'b0;
            mem_wen  = 1'b0;
            mem_addr = row_cnt_q;
            mem_din  = wr_data;
            if (row_cnt_q == row_last) begin
               row_cnt_d   = '0;
               iter_done_d = 1'b1;
               state_d     = kij_cnt_q == kij_last ? DONE : POP;
               kij_cnt_d   = kij_cnt_q == kij_last ? kij_cnt_q : kij_cnt_q + 1'b1;
            end else begin
               row_cnt_d = row_cnt_q + 1'b1;
               state_d   = POP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy         = state_q != IDLE && state_q != DONE;
   assign compute_done = state_q == DONE;
   assign iter_done    = iter_done_q;
endmodule
